// File: rtl/fft_frame_loader_if.sv
// Signal bundle between the audio sample stream, fft_frame_loader and the 16-point FFT core.
// Handshakes: sample_valid is a one-cycle strobe with no backpressure (an unstorable sample is dropped and counted); fft_start rises with frame0..15 and holds them stable until fft_done is sampled high.
interface fft_frame_loader_if #(
    parameter int SAMPLE_W   = 24,
    parameter int DROP_CNT_W = 8
);
    logic                  enable;
    logic [SAMPLE_W-1:0]   sample_in;
    logic                  sample_valid;
    logic                  fft_done;
    logic                  fft_start;
    logic [35:0]           frame0, frame1, frame2, frame3, frame4, frame5, frame6, frame7;
    logic [35:0]           frame8, frame9, frame10, frame11, frame12, frame13, frame14, frame15;
    logic                  busy;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_count;
    logic [1:0]            state_dbg;

    modport master (
        input  enable, sample_in, sample_valid, fft_done,
        output fft_start, busy, overflow, drop_count, state_dbg,
        output frame0, frame1, frame2, frame3, frame4, frame5, frame6, frame7,
        output frame8, frame9, frame10, frame11, frame12, frame13, frame14, frame15
    );

    modport slave (
        output enable, sample_in, sample_valid, fft_done,
        input  fft_start, busy, overflow, drop_count, state_dbg,
        input  frame0, frame1, frame2, frame3, frame4, frame5, frame6, frame7,
        input  frame8, frame9, frame10, frame11, frame12, frame13, frame14, frame15
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Ping-pong frame collector for the 16-point FFT: converts samples to Q1.17 complex words,
// buffers two 16-entry banks and presents each full bank in bit-reversed order with a start/done handshake.
module fft_frame_loader #(
    parameter int SAMPLE_W   = 24,
    parameter int PRESCALE   = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    fft_frame_loader_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RELEASE = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [17:0]           mem_q [2][16];
    logic [17:0]           mem_d [2][16];
    logic [35:0]           frame_q [16];
    logic [35:0]           frame_d [16];
    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [3:0]            wr_idx_q, wr_idx_d;
    logic                  sel_q, sel_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic signed [17:0]    conv_real;
    logic                  accept, drop, load, load_bank;

    function automatic logic [3:0] bitrev4(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    always_comb begin
        conv_real  = $signed(bus.sample_in[SAMPLE_W-1 -: 18]) >>> PRESCALE;
        accept     = bus.sample_valid && bus.enable && !full_q[wr_bank_q];
        drop       = bus.sample_valid && bus.enable && full_q[wr_bank_q];
        mem_d      = mem_q;
        frame_d    = frame_q;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        wr_idx_d   = wr_idx_q;
        state_d    = state_q;
        sel_d      = sel_q;
        start_d    = start_q;
        load       = 1'b0;
        load_bank  = 1'b0;
        overflow_d = drop;
        drop_d     = drop_q;

        if (!bus.enable) begin
            wr_idx_d = '0;
        end else if (accept) begin
            mem_d[wr_bank_q][wr_idx_q] = conv_real;
            wr_idx_d = wr_idx_q + 4'd1;
            if (wr_idx_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        if (drop && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);

        // Banks fill strictly alternately, so with both full the older one is the current write bank.
        case (state_q)
            IDLE: begin
                if (|full_q) begin
                    load      = 1'b1;
                    load_bank = (&full_q) ? wr_bank_q : full_q[1];
                end
            end
            WAIT: begin
                if (bus.fft_done) begin
                    start_d = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                full_d[sel_q] = 1'b0;
                state_d       = IDLE;
                // A bank already waiting starts straight after the single low cycle.
                if (full_q[!sel_q]) begin
                    load      = 1'b1;
                    load_bank = !sel_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            sel_d   = load_bank;
            start_d = 1'b1;
            state_d = WAIT;
            for (int k = 0; k < 16; k++) frame_d[bitrev4(4'(k))] = {mem_q[load_bank][4'(k)], 18'h0};
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            sel_q      <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < 16; k++) mem_q[b][k] <= '0;
            for (int k = 0; k < 16; k++) frame_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            wr_idx_q   <= wr_idx_d;
            sel_q      <= sel_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            mem_q      <= mem_d;
            frame_q    <= frame_d;
        end
    end

    generate
        if (SAMPLE_W > 18) begin : g_lsbs
            logic unused_lsbs;
            assign unused_lsbs = ^bus.sample_in[SAMPLE_W-19:0];
        end
    endgenerate

    assign bus.fft_start  = start_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;
    assign bus.state_dbg  = state_q;
    assign bus.frame0     = frame_q[0];
    assign bus.frame1     = frame_q[1];
    assign bus.frame2     = frame_q[2];
    assign bus.frame3     = frame_q[3];
    assign bus.frame4     = frame_q[4];
    assign bus.frame5     = frame_q[5];
    assign bus.frame6     = frame_q[6];
    assign bus.frame7     = frame_q[7];
    assign bus.frame8     = frame_q[8];
    assign bus.frame9     = frame_q[9];
    assign bus.frame10    = frame_q[10];
    assign bus.frame11    = frame_q[11];
    assign bus.frame12    = frame_q[12];
    assign bus.frame13    = frame_q[13];
    assign bus.frame14    = frame_q[14];
    assign bus.frame15    = frame_q[15];
endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed, table-driven bench for fft_frame_loader with a small FFT done-responder.
module tb_fft_frame_loader;
  localparam int SAMPLE_W   = 24;
  localparam int DROP_CNT_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_frame_loader_if #(.SAMPLE_W(SAMPLE_W), .DROP_CNT_W(DROP_CNT_W)) bus ();

  fft_frame_loader #(.SAMPLE_W(SAMPLE_W), .PRESCALE(4), .DROP_CNT_W(DROP_CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] sample;
    int          port;
    logic [17:0] exp_real;
  } vec_t;

  vec_t tbl[32];
  int   tests = 0;
  int   fails = 0;
  int   fft_delay = 6;
  bit   fft_hold = 1'b0;
  int   fft_cnt = 0;
  int   n_hi;

  // FFT model: raises done once start has been high for fft_delay cycles
  initial begin
    bus.fft_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus.fft_start && !fft_hold) begin
        fft_cnt++;
        bus.fft_done = (fft_cnt >= fft_delay);
      end else begin
        fft_cnt = 0;
        bus.fft_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [23:0] s);
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic set_vec(input int i, input logic [23:0] s, input int p, input logic [17:0] r);
    tbl[i].sample   = s;
    tbl[i].port     = p;
    tbl[i].exp_real = r;
  endtask

  function automatic logic [35:0] frame_at(input int p);
    case (p)
      0:  return bus.frame0;
      1:  return bus.frame1;
      2:  return bus.frame2;
      3:  return bus.frame3;
      4:  return bus.frame4;
      5:  return bus.frame5;
      6:  return bus.frame6;
      7:  return bus.frame7;
      8:  return bus.frame8;
      9:  return bus.frame9;
      10: return bus.frame10;
      11: return bus.frame11;
      12: return bus.frame12;
      13: return bus.frame13;
      14: return bus.frame14;
      default: return bus.frame15;
    endcase
  endfunction

  task automatic wait_fall(input int limit, output int n);
    n = 0;
    while (bus.fft_start && n < limit) begin
      tick();
      n++;
    end
    check("start_fall", 64'(bus.fft_start), 64'd0);
  endtask

  // Send one table frame, then check start latency and every frame port
  task automatic run_frame(input int base, input bit gaps);
    for (int k = 0; k < 16; k++) begin
      send(tbl[base + k].sample);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
    check("start_not_yet", 64'(bus.fft_start), 64'd0);
    tick();
    check("start_rise", 64'(bus.fft_start), 64'd1);
    check("busy_wait", 64'(bus.busy), 64'd1);
    for (int k = 0; k < 16; k++)
      check($sformatf("frame%0d_v%0d", tbl[base + k].port, base + k),
            64'(frame_at(tbl[base + k].port)), 64'({tbl[base + k].exp_real, 18'h0}));
  endtask

  initial begin
    // Frame A: sample k = k * 24'h010000 -> real k * 18'h40, port bitrev(k)
    set_vec(0,  24'h000000, 0,  18'h00000); set_vec(1,  24'h010000, 8,  18'h00040);
    set_vec(2,  24'h020000, 4,  18'h00080); set_vec(3,  24'h030000, 12, 18'h000C0);
    set_vec(4,  24'h040000, 2,  18'h00100); set_vec(5,  24'h050000, 10, 18'h00140);
    set_vec(6,  24'h060000, 6,  18'h00180); set_vec(7,  24'h070000, 14, 18'h001C0);
    set_vec(8,  24'h080000, 1,  18'h00200); set_vec(9,  24'h090000, 9,  18'h00240);
    set_vec(10, 24'h0A0000, 5,  18'h00280); set_vec(11, 24'h0B0000, 13, 18'h002C0);
    set_vec(12, 24'h0C0000, 3,  18'h00300); set_vec(13, 24'h0D0000, 11, 18'h00340);
    set_vec(14, 24'h0E0000, 7,  18'h00380); set_vec(15, 24'h0F0000, 15, 18'h003C0);
    // Frame B: conversion extremes and sign handling
    set_vec(16, 24'h7FFFFF, 0,  18'h01FFF); set_vec(17, 24'h800000, 8,  18'h3E000);
    set_vec(18, 24'hFFFFFF, 4,  18'h3FFFF); set_vec(19, 24'h000000, 12, 18'h00000);
    set_vec(20, 24'h123456, 2,  18'h0048D); set_vec(21, 24'hFEDCBA, 10, 18'h3FFB7);
    set_vec(22, 24'h400000, 6,  18'h01000); set_vec(23, 24'hC00000, 14, 18'h3F000);
    set_vec(24, 24'h000400, 1,  18'h00001); set_vec(25, 24'h00003F, 9,  18'h00000);
    set_vec(26, 24'hFFFFC0, 5,  18'h3FFFF); set_vec(27, 24'h010000, 13, 18'h00040);
    set_vec(28, 24'hF00000, 3,  18'h3FC00); set_vec(29, 24'h080000, 11, 18'h00200);
    set_vec(30, 24'hFF0000, 7,  18'h3FFC0); set_vec(31, 24'h000800, 15, 18'h00002);

    reset = 1'b1;
    bus.enable = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in = 24'h5A5A5A;
    repeat (3) tick();
    check("rst_start", 64'(bus.fft_start), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_drop_count", 64'(bus.drop_count), 64'd0);
    check("rst_state", 64'(bus.state_dbg), 64'd0);
    check("rst_frame0", 64'(bus.frame0), 64'd0);
    check("rst_frame15", 64'(bus.frame15), 64'd0);
    reset = 1'b0;
    tick();

    // Frame A back-to-back, start held exactly fft_delay cycles, one release cycle
    run_frame(0, 1'b0);
    wait_fall(50, n_hi);
    check("start_high_cycles", 64'(n_hi), 64'd6);
    check("release_busy", 64'(bus.busy), 64'd1);
    tick();
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_state", 64'(bus.state_dbg), 64'd0);

    // Frame B with irregular gaps; frames held after return to IDLE
    run_frame(16, 1'b1);
    wait_fall(50, n_hi);
    repeat (2) tick();
    check("idle_hold_frame8", 64'(bus.frame8), 64'({18'h3E000, 18'h0}));
    check("idle_hold_start", 64'(bus.fft_start), 64'd0);

    // Back-to-back: 48 samples, long FFT; samples 32..47 drop
    fft_delay = 40;
    for (int n = 0; n < 48; n++) begin
      send(24'(n) << 16);
      if (n == 16) check("b2b_first_start", 64'(bus.fft_start), 64'd1);
      if (n == 31) check("b2b_ovf_before", 64'(bus.overflow), 64'd0);
      if (n == 32) check("b2b_ovf_first", 64'(bus.overflow), 64'd1);
    end
    check("b2b_drop_count", 64'(bus.drop_count), 64'd16);
    tick();
    check("b2b_ovf_idle", 64'(bus.overflow), 64'd0);
    wait_fall(100, n_hi);
    check("b2b_release_busy", 64'(bus.busy), 64'd1);
    // Sample in the release cycle hits the not-yet-free bank
    send(24'h110000);
    check("rel_drop_count", 64'(bus.drop_count), 64'd17);
    check("rel_drop_ovf", 64'(bus.overflow), 64'd1);
    check("b2b_second_start", 64'(bus.fft_start), 64'd1);
    check("b2b_f0", 64'(bus.frame0), 64'({18'h00400, 18'h0}));
    check("b2b_f8", 64'(bus.frame8), 64'({18'h00440, 18'h0}));
    check("b2b_f1", 64'(bus.frame1), 64'({18'h00600, 18'h0}));
    check("b2b_f15", 64'(bus.frame15), 64'({18'h007C0, 18'h0}));
    send(24'h120000);
    check("after_rel_accept", 64'(bus.drop_count), 64'd17);
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;

    // Saturation: hold done low, fill the free bank, then flood
    fft_hold = 1'b1;
    for (int n = 0; n < 16; n++) send(24'h020000);
    check("sat_fill_nodrop", 64'(bus.drop_count), 64'd17);
    for (int n = 0; n < 100; n++) send(24'h030000);
    check("sat_mid", 64'(bus.drop_count), 64'd117);
    for (int n = 0; n < 200; n++) send(24'h030000);
    check("sat_full", 64'(bus.drop_count), 64'hFF);
    check("sat_ovf", 64'(bus.overflow), 64'd1);
    check("sat_still_wait", 64'(bus.fft_start), 64'd1);

    // Reset while in WAIT
    reset = 1'b1;
    tick();
    check("midrst_start", 64'(bus.fft_start), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_drop", 64'(bus.drop_count), 64'd0);
    check("midrst_frame8", 64'(bus.frame8), 64'd0);
    reset = 1'b0;
    fft_hold = 1'b0;
    fft_delay = 6;
    tick();

    // Partial frame discarded by enable low, ignored samples while disabled
    for (int n = 0; n < 7; n++) send(24'h7F0000);
    bus.enable = 1'b0;
    send(24'h7F0000);
    send(24'h7F0000);
    check("dis_ovf", 64'(bus.overflow), 64'd0);
    check("dis_drop", 64'(bus.drop_count), 64'd0);
    repeat (3) tick();
    check("dis_no_start", 64'(bus.fft_start), 64'd0);
    bus.enable = 1'b1;
    for (int n = 0; n < 16; n++) send(24'(n + 32) << 16);
    check("fresh_not_yet", 64'(bus.fft_start), 64'd0);
    tick();
    check("fresh_start", 64'(bus.fft_start), 64'd1);
    check("fresh_f0", 64'(bus.frame0), 64'({18'h00800, 18'h0}));
    check("fresh_f8", 64'(bus.frame8), 64'({18'h00840, 18'h0}));
    check("fresh_f14", 64'(bus.frame14), 64'({18'h009C0, 18'h0}));
    check("fresh_f15", 64'(bus.frame15), 64'({18'h00BC0, 18'h0}));
    wait_fall(50, n_hi);
    check("fresh_high_cycles", 64'(n_hi), 64'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
